// File: rtl/ps2_voice_allocator.sv
// Parses PS/2 make/break/extended scan-code sequences, maps 13 keys to notes,
// and allocates notes to NUM_VOICES voices (lowest free voice, else steal the oldest).
module ps2_voice_allocator #(
    parameter int NUM_VOICES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                scan_code,
    input  logic                      scan_valid,
    output logic [4*NUM_VOICES-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [NUM_VOICES-1:0]     voice_trig,
    output logic                      voice_stolen
);

    localparam int RW = $clog2(NUM_VOICES);

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        EXT,
        EXT_BREAK
    } state_t;

    state_t         state;
    logic [3:0]     note_r [NUM_VOICES];
    logic [RW-1:0]  rank_r [NUM_VOICES];

    logic [4:0]     key;
    logic           mapped;
    logic [3:0]     key_note;
    logic           make_evt;
    logic           break_evt;
    logic           hit;
    logic [RW-1:0]  hit_idx;
    logic           free;
    logic [RW-1:0]  free_idx;
    logic [RW-1:0]  old_idx;
    logic [RW-1:0]  alloc_idx;

    // Returns {mapped, note}; F0/E0 are never mapped.
    function automatic logic [4:0] key_map(input logic [7:0] code);
        case (code)
            8'h1A:   key_map = {1'b1, 4'd0};
            8'h1B:   key_map = {1'b1, 4'd1};
            8'h22:   key_map = {1'b1, 4'd2};
            8'h23:   key_map = {1'b1, 4'd3};
            8'h21:   key_map = {1'b1, 4'd4};
            8'h2A:   key_map = {1'b1, 4'd5};
            8'h34:   key_map = {1'b1, 4'd6};
            8'h32:   key_map = {1'b1, 4'd7};
            8'h33:   key_map = {1'b1, 4'd8};
            8'h31:   key_map = {1'b1, 4'd9};
            8'h3B:   key_map = {1'b1, 4'd10};
            8'h3A:   key_map = {1'b1, 4'd11};
            8'h41:   key_map = {1'b1, 4'd12};
            default: key_map = 5'd0;
        endcase
    endfunction

    always_comb begin
        key       = key_map(scan_code);
        mapped    = key[4];
        key_note  = key[3:0];
        make_evt  = scan_valid && (state == IDLE)  && mapped;
        break_evt = scan_valid && (state == BREAK) && mapped;

        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        old_idx  = '0;
        // Descending scan so the lowest matching index is the one kept.
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_gate[i] && (note_r[i] == key_note)) begin
                hit     = 1'b1;
                hit_idx = RW'(i);
            end
            if (!voice_gate[i]) begin
                free     = 1'b1;
                free_idx = RW'(i);
            end
            if (rank_r[i] == RW'(NUM_VOICES - 1)) begin
                old_idx = RW'(i);
            end
        end
        alloc_idx = free ? free_idx : old_idx;
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
        assign voice_note[4*g +: 4] = note_r[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            voice_gate   <= '0;
            voice_trig   <= '0;
            voice_stolen <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                note_r[i] <= 4'd0;
                rank_r[i] <= RW'(i);
            end
        end else begin
            voice_trig   <= '0;
            voice_stolen <= 1'b0;

            if (scan_valid) begin
                case (state)
                    IDLE: begin
                        if (scan_code == CODE_BREAK)     state <= BREAK;
                        else if (scan_code == CODE_EXT)  state <= EXT;
                    end
                    BREAK: begin
                        if (scan_code == CODE_BREAK)     state <= BREAK;
                        else if (scan_code == CODE_EXT)  state <= EXT;
                        else                             state <= IDLE;
                    end
                    EXT: begin
                        if (scan_code == CODE_BREAK)     state <= EXT_BREAK;
                        else                             state <= IDLE;
                    end
                    default:                             state <= IDLE;
                endcase
            end

            // A repeat of an already-sounding note is typematic and changes nothing.
            if (make_evt && !hit) begin
                note_r[alloc_idx]     <= key_note;
                voice_gate[alloc_idx] <= 1'b1;
                voice_trig[alloc_idx] <= 1'b1;
                voice_stolen          <= !free;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (RW'(i) == alloc_idx)
                        rank_r[i] <= '0;
                    else if (rank_r[i] < rank_r[alloc_idx])
                        rank_r[i] <= rank_r[i] + 1'b1;
                end
            end

            // Note is kept on release so the tone generator's tail keeps its pitch.
            if (break_evt && hit) begin
                voice_gate[hit_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Scoreboard bench: a queue/array reference model predicts voice outputs per byte;
// a monitor compares them the cycle after each byte or reset.
module tb_ps2_voice_allocator;

    localparam int NV = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      scan_code;
    logic            scan_valid;
    logic [4*NV-1:0] voice_note;
    logic [NV-1:0]   voice_gate;
    logic [NV-1:0]   voice_trig;
    logic            voice_stolen;

    ps2_voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk          (clk),
        .reset        (reset),
        .scan_code    (scan_code),
        .scan_valid   (scan_valid),
        .voice_note   (voice_note),
        .voice_gate   (voice_gate),
        .voice_trig   (voice_trig),
        .voice_stolen (voice_stolen)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*NV-1:0] note;
        logic [NV-1:0]   gate;
        logic [NV-1:0]   trig;
        logic            stolen;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    // Reference model: plain arrays plus an age list (front = newest voice).
    int   m_note[NV];
    bit   m_gate[NV];
    int   age_q[$];
    bit   pend_break;
    bit   pend_ext;
    bit   pend_ext_break;

    byte unsigned keys[13] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34,
                               8'h32, 8'h33, 8'h31, 8'h3B, 8'h3A, 8'h41};

    function automatic int key_note(input byte unsigned c);
        for (int k = 0; k < 13; k++) if (keys[k] == c) return k;
        return -1;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t snap(input logic [NV-1:0] trig, input logic stolen);
        exp_t e;
        for (int v = 0; v < NV; v++) begin
            e.note[4*v +: 4] = 4'(m_note[v]);
            e.gate[v]        = m_gate[v];
        end
        e.trig   = trig;
        e.stolen = stolen;
        return e;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_note[v] = 0;
            m_gate[v] = 0;
        end
        age_q = {};
        for (int v = 0; v < NV; v++) age_q.push_back(v);
        pend_break = 0;
        pend_ext = 0;
        pend_ext_break = 0;
    endtask

    task automatic model_byte(input byte unsigned b, output exp_t e);
        logic [NV-1:0] trig = '0;
        logic          stolen = 1'b0;
        int            n = key_note(b);
        int            v;
        bit            held;
        if (pend_ext_break) begin
            pend_ext_break = 0;
        end else if (pend_ext) begin
            pend_ext = 0;
            if (b == 8'hF0) pend_ext_break = 1;
        end else if (b == 8'hF0) begin
            pend_break = 1;
        end else if (b == 8'hE0) begin
            pend_break = 0;
            pend_ext = 1;
        end else if (pend_break) begin
            pend_break = 0;
            if (n >= 0)
                for (int i = 0; i < NV; i++)
                    if (m_gate[i] && m_note[i] == n) m_gate[i] = 0;
        end else if (n >= 0) begin
            held = 0;
            for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == n) held = 1;
            if (!held) begin
                v = -1;
                for (int i = NV - 1; i >= 0; i--) if (!m_gate[i]) v = i;
                if (v < 0) begin
                    v = age_q[$];
                    stolen = 1'b1;
                end
                m_note[v] = n;
                m_gate[v] = 1;
                trig[v]   = 1'b1;
                for (int i = 0; i < age_q.size(); i++)
                    if (age_q[i] == v) begin
                        age_q.delete(i);
                        break;
                    end
                age_q.push_front(v);
            end
        end
        e = snap(trig, stolen);
    endtask

    // All stimulus tasks are entered and left on a falling edge.
    task automatic send(input byte unsigned b);
        exp_t e;
        scan_code  = b;
        scan_valid = 1'b1;
        model_byte(b, e);
        sbq.push_back(e);
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int cycles, input bit with_byte);
        reset      = 1'b1;
        scan_valid = with_byte;
        scan_code  = 8'h1A;
        model_reset();
        repeat (cycles) begin
            sbq.push_back(snap('0, 1'b0));
            @(negedge clk);
        end
        reset      = 1'b0;
        scan_valid = 1'b0;
    endtask

    logic ev_d;
    always @(posedge clk) ev_d <= reset || scan_valid;

    always @(negedge clk) begin
        exp_t e;
        if (ev_d === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("scoreboard_underflow", 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("voice_note",   32'(voice_note),   32'(e.note));
                chk("voice_gate",   32'(voice_gate),   32'(e.gate));
                chk("voice_trig",   32'(voice_trig),   32'(e.trig));
                chk("voice_stolen", 32'(voice_stolen), 32'(e.stolen));
            end
        end else if (ev_d === 1'b0) begin
            chk("idle_trig",   32'(voice_trig),   32'd0);
            chk("idle_stolen", 32'(voice_stolen), 32'd0);
        end
    end

    byte unsigned pool[6] = '{8'hF0, 8'hE0, 8'h1C, 8'h00, 8'h5A, 8'hFF};

    initial begin
        byte unsigned b;
        int           r;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        reset      = 1'b1;
        do_reset(2, 1'b0);

        // First make after reset
        send(8'h1A);
        idle(2);

        // Fill all voices, then steal the oldest
        do_reset(1, 1'b0);
        send(8'h1A); send(8'h1B); send(8'h22); send(8'h23);
        send(8'h21);
        idle(1);

        // Typematic repeats
        do_reset(1, 1'b0);
        send(8'h1A); idle(1); send(8'h1A); send(8'h1A);
        idle(1);

        // Release keeps pitch, then reuse freed voice
        do_reset(1, 1'b0);
        send(8'h1A); send(8'h1B); send(8'hF0); send(8'h1A);
        idle(1);
        send(8'h22);
        idle(1);

        // Extended sequences, double F0, unmapped code
        do_reset(1, 1'b0);
        send(8'h1A); send(8'h1B);
        send(8'hE0); send(8'h1A);
        send(8'hE0); send(8'hF0); send(8'h1A);
        send(8'hF0); send(8'hF0); send(8'h1B);
        send(8'h1C);
        idle(1);

        // Dangling F0 discarded by reset; byte during reset dropped
        send(8'hF0);
        do_reset(1, 1'b1);
        send(8'h1A);
        idle(1);

        // Randomized traffic
        for (int t = 0; t < 3000; t++) begin
            r = $urandom_range(0, 99);
            if (r < 62)      b = keys[$urandom_range(0, 12)];
            else if (r < 80) b = 8'hF0;
            else if (r < 88) b = 8'hE0;
            else             b = pool[$urandom_range(2, 5)];
            send(b);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if ($urandom_range(0, 299) == 0) do_reset(1, $urandom_range(0, 1) == 1);
        end

        idle(3);
        chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
